bmult_share_arbiter: RTL and testbench
======================================

Name: bmult_share_arbiter

Overview:
Shares one pipelined Bmult multiplier instance (default 22x22) among NUM_REQ requesters. Each requester has a valid/ready operand port. The block arbitrates round-robin, registers the winning operands onto the multiplier inputs, and tracks each in-flight product's requester ID through a latency-matched tag pipeline. Finished products are buffered in an in-order response FIFO. Issue is credit-limited, so the FIFO can never overflow under rsp_ready backpressure. The block sits between requesting engines and the multiplier's A/B/P pins.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
AW, 22, operand A width
BW, 22, operand B width
MULT_LAT, 1, cycles from mult_a/mult_b register update to a valid mult_p (>=1)
FIFO_DEPTH, 4, response FIFO entries; also the issue credit limit (>=1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester operand valid
req_ready  output  NUM_REQ  per-requester accept (one-hot or zero)
req_a  input  NUM_REQ*AW  operand A, requester i at bits [i*AW +: AW]
req_b  input  NUM_REQ*BW  operand B, requester i at bits [i*BW +: BW]
mult_a  output  AW  registered A to multiplier
mult_b  output  BW  registered B to multiplier
mult_p  input  AW+BW  multiplier product
rsp_valid  output  1  response available
rsp_ready  input  1  response consumer accept
rsp_id  output  $clog2(NUM_REQ)  requester index of the product
rsp_p  output  AW+BW  product
busy  output  1  product in flight or FIFO non-empty

Behaviour:
- Reset (async assert, sync release):
  - outputs: req_ready=0, mult_a=0, mult_b=0, rsp_valid=0, busy=0
  - state: RR pointer=0, tag pipeline valids=0, FIFO emptied, in-flight count=0
  - reset mid-operation discards all in-flight and buffered products; no response is produced for them.
- Credits:
  - inflight = number of valid tag-pipeline stages; occ = FIFO count.
  - issue_ok = (inflight + occ) < FIFO_DEPTH, using registered values only.
  - A same-cycle pop does not free a credit until the next cycle.
- Arbitration (combinational):
  - Search req_valid starting at index ptr+1 (mod NUM_REQ), wrapping; the first set bit wins. After reset ptr=0, so the first search begins at index 1.
  - req_ready[win]=issue_ok; all other bits are 0. req_ready may depend on req_valid.
  - Requesters must hold valid and operands stable until accepted.
- Issue (edge where req_valid[i]&req_ready[i]):
  - mult_a <= req_a[i], mult_b <= req_b[i]; tag stage 0 <= {1, i}; ptr <= i.
  - With no issue, mult_a/mult_b hold their value and tag stage 0 valid <= 0.
- Tag pipeline:
  - MULT_LAT stages, shifting every cycle unconditionally.
  - When the last stage is valid, mult_p and its id are pushed into the FIFO on that edge.
  - Accept at edge k: mult_a updates at k, product is captured at edge k+MULT_LAT, rsp_valid rises the cycle after. Accept-to-rsp_valid is MULT_LAT+1 cycles.
- Response FIFO:
  - Order is first-in first-out, so responses follow issue order.
  - rsp_valid = occ!=0; rsp_id/rsp_p show the head entry.
  - Pop on rsp_valid&rsp_ready. Push and pop in the same cycle are both performed and occ is unchanged.
  - Push while full cannot occur by construction; the verifier asserts this.
- Throughput: one issue per cycle sustained when rsp_ready=1 and FIFO_DEPTH >= MULT_LAT+1.
- busy = (inflight!=0) | (occ!=0).
- Product width is AW+BW, unsigned, and passes unmodified.

Test Plan:
1. Reset then single request: req 2 sends A=22'h3FFFFF, B=22'h3FFFFF with MULT_LAT=1 → req_ready[2]=1 in the request cycle; 2 cycles later rsp_valid=1, rsp_id=2, rsp_p=44'hFFFFF800001; busy falls after pop.
2. All 4 requesters valid continuously, rsp_ready=1, A=i+1, B=3 → grants in order 1,2,3,0,1,… one per cycle; responses carry matching ids with products 3·(id+1).
3. rsp_ready=0, all requesters valid → exactly FIFO_DEPTH=4 accepts, then req_ready stays 0. Raising rsp_ready drains in order, and issue resumes one cycle after the first pop.
4. Simultaneous push and pop with occ=3 → occ stays 3 and no data is lost or duplicated. Scoreboard compares every rsp_p against A·B for its id.
5. Assert rst_n low with 1 product in flight and 2 buffered → all outputs 0 immediately. After release no stale response appears, and the first new grant searches from index 1.
6. MULT_LAT=3, FIFO_DEPTH=4, single requester 0 streaming → back-to-back accepts; each response arrives 4 cycles after its accept.

Source files
------------

// File: rtl/bmult_share_arbiter.sv
// Round-robin share of one pipelined multiplier among NUM_REQ requesters.
// Products return through an in-order response FIFO; issue is credit-limited so the FIFO never overflows.
module bmult_share_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int AW         = 22,
  parameter int BW         = 22,
  parameter int MULT_LAT   = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*AW-1:0]      req_a,
  input  logic [NUM_REQ*BW-1:0]      req_b,
  output logic [AW-1:0]              mult_a,
  output logic [BW-1:0]              mult_b,
  input  logic [AW+BW-1:0]           mult_p,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [AW+BW-1:0]           rsp_p,
  output logic                       busy
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH + MULT_LAT + 1) + 1;
  localparam int PRW = AW + BW;

  logic [IDW-1:0]      r_ptr;
  logic [AW-1:0]       r_a;
  logic [BW-1:0]       r_b;
  logic [MULT_LAT-1:0] r_tag_v;
  logic [IDW-1:0]      r_tag_id [MULT_LAT];
  logic [CW-1:0]       r_inflight;
  logic [CW-1:0]       r_occ;
  logic [PW-1:0]       r_wr;
  logic [PW-1:0]       r_rd;
  logic [IDW-1:0]      r_mem_id [FIFO_DEPTH];
  logic [PRW-1:0]      r_mem_p  [FIFO_DEPTH];

  logic           w_issue_ok;
  logic           w_found;
  logic           w_hit;
  logic [IDW-1:0] w_cand;
  logic [IDW-1:0] w_win;
  logic           w_issue;
  logic           w_push;
  logic           w_pop;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    f_inc = (p == PW'(FIFO_DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
  endfunction

  // Credits count only registered state, so a pop frees its slot one cycle later.
  assign w_issue_ok = rst_n & ((r_inflight + r_occ) < CW'(FIFO_DEPTH));
  assign w_issue    = w_found & w_issue_ok;
  assign w_push     = r_tag_v[MULT_LAT-1];
  assign w_pop      = rsp_valid & rsp_ready;

  // Round-robin search starting one past the last winner.
  always_comb begin
    w_found = 1'b0;
    w_win   = {IDW{1'b0}};
    w_cand  = {IDW{1'b0}};
    w_hit   = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand  = IDW'((int'(r_ptr) + k) % NUM_REQ);
      w_hit   = req_valid[w_cand] & ~w_found;
      w_win   = w_hit ? w_cand : w_win;
      w_found = w_found | w_hit;
    end
  end

  assign req_ready = w_issue ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << w_win) : {NUM_REQ{1'b0}};

  // Operand registers feeding the multiplier, plus the arbitration pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= {AW{1'b0}};
      r_b   <= {BW{1'b0}};
      r_ptr <= {IDW{1'b0}};
    end else if (w_issue) begin
      r_a   <= req_a[w_win*AW +: AW];
      r_b   <= req_b[w_win*BW +: BW];
      r_ptr <= w_win;
    end
  end

  // Requester-id tags travel alongside the multiplier pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_v    <= {MULT_LAT{1'b0}};
      r_inflight <= {CW{1'b0}};
      for (int i = 0; i < MULT_LAT; i++) r_tag_id[i] <= {IDW{1'b0}};
    end else begin
      r_tag_v[0]  <= w_issue;
      r_tag_id[0] <= w_win;
      for (int i = 1; i < MULT_LAT; i++) begin
        r_tag_v[i]  <= r_tag_v[i-1];
        r_tag_id[i] <= r_tag_id[i-1];
      end
      r_inflight <= r_inflight + CW'(w_issue) - CW'(w_push);
    end
  end

  // Response FIFO; simultaneous push and pop leave the occupancy unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= {PW{1'b0}};
      r_rd  <= {PW{1'b0}};
      r_occ <= {CW{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_id[i] <= {IDW{1'b0}};
        r_mem_p[i]  <= {PRW{1'b0}};
      end
    end else begin
      if (w_push) begin
        r_mem_id[r_wr] <= r_tag_id[MULT_LAT-1];
        r_mem_p[r_wr]  <= mult_p;
        r_wr           <= f_inc(r_wr);
      end
      if (w_pop) begin
        r_rd <= f_inc(r_rd);
      end
      r_occ <= r_occ + CW'(w_push) - CW'(w_pop);
    end
  end

  assign mult_a    = r_a;
  assign mult_b    = r_b;
  assign rsp_valid = (r_occ != {CW{1'b0}});
  assign rsp_id    = r_mem_id[r_rd];
  assign rsp_p     = r_mem_p[r_rd];
  assign busy      = (r_inflight != {CW{1'b0}}) | (r_occ != {CW{1'b0}});

endmodule

// File: tb/tb_bmult_share_arbiter.sv
// Bench for bmult_share_arbiter: a MULT_LAT=1 instance and a MULT_LAT=3 instance, each checked
// every cycle against a queue-based transaction model, plus directed literal checks.
module tb_bmult_share_arbiter;

  localparam int DEPTH = 4;

  typedef struct packed { logic [1:0] id; logic [43:0] p; int t; } pent_t;
  typedef struct packed { logic [1:0] id; logic [43:0] p; } fent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  req_valid0, req_valid1, req_ready0, req_ready1;
  logic [87:0] req_a0, req_a1, req_b0, req_b1;
  logic [21:0] mult_a0, mult_a1, mult_b0, mult_b1;
  logic [43:0] mult_p0, mult_p1, p1_d1, p1_d2;
  logic        rsp_valid0, rsp_valid1, rsp_ready0, rsp_ready1, busy0, busy1;
  logic [1:0]  rsp_id0, rsp_id1;
  logic [43:0] rsp_p0, rsp_p1;

  logic [3:0]  g_mask [2];
  int          g_rmode [2];
  int          g_opmode;
  logic        g_vrand;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  pent_t       pipe_q [2][$];
  fent_t       fifo_q [2][$];
  int          m_ptr [2];
  logic [21:0] m_a [2];
  logic [21:0] m_b [2];

  bmult_share_arbiter #(.NUM_REQ(4), .AW(22), .BW(22), .MULT_LAT(1), .FIFO_DEPTH(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_a(req_a0), .req_b(req_b0), .mult_a(mult_a0), .mult_b(mult_b0), .mult_p(mult_p0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_id(rsp_id0), .rsp_p(rsp_p0), .busy(busy0));

  bmult_share_arbiter #(.NUM_REQ(4), .AW(22), .BW(22), .MULT_LAT(3), .FIFO_DEPTH(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_a(req_a1), .req_b(req_b1), .mult_a(mult_a1), .mult_b(mult_b1), .mult_p(mult_p1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_id(rsp_id1), .rsp_p(rsp_p1), .busy(busy1));

  // External multipliers: combinational for latency 1, two extra registers for latency 3.
  assign mult_p0 = 44'(mult_a0) * 44'(mult_b0);
  always @(posedge clk) begin
    p1_d1 <= 44'(mult_a1) * 44'(mult_b1);
    p1_d2 <= p1_d1;
  end
  assign mult_p1 = p1_d2;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One model step: compare the DUT against the expected state, then advance to the next edge.
  task automatic model_step(input int c, input int lat, input logic [3:0] vld, input logic [3:0] rdy,
                            input logic [87:0] a, input logic [87:0] b, input logic rv, input logic rr,
                            input logic [1:0] id, input logic [43:0] p, input logic bz,
                            input logic [21:0] ma, input logic [21:0] mb);
    int win;
    logic [3:0] exp_rdy;
    pent_t e;
    fent_t f;
    if (!rst_n) begin
      pipe_q[c].delete();
      fifo_q[c].delete();
      m_ptr[c] = 0;
      m_a[c] = 22'h0;
      m_b[c] = 22'h0;
      chk($sformatf("c%0d_rst_outs", c), {rdy, rv, bz, ma, mb}, 64'h0);
      return;
    end
    win = -1;
    for (int k = 1; k <= 4; k++) begin
      int idx;
      idx = (m_ptr[c] + k) % 4;
      if (win < 0 && vld[idx]) win = idx;
    end
    exp_rdy = 4'b0000;
    if (win >= 0 && (pipe_q[c].size() + fifo_q[c].size()) < DEPTH) exp_rdy[win] = 1'b1;
    chk($sformatf("c%0d_req_ready", c), rdy, exp_rdy);
    chk($sformatf("c%0d_rsp_valid", c), rv, fifo_q[c].size() != 0);
    if (fifo_q[c].size() != 0) begin
      chk($sformatf("c%0d_rsp_id", c), id, fifo_q[c][0].id);
      chk($sformatf("c%0d_rsp_p", c), p, fifo_q[c][0].p);
    end
    chk($sformatf("c%0d_busy", c), bz, (fifo_q[c].size() != 0) || (pipe_q[c].size() != 0));
    chk($sformatf("c%0d_mult_ab", c), {ma, mb}, {m_a[c], m_b[c]});
    if (fifo_q[c].size() != 0 && rr) void'(fifo_q[c].pop_front());
    if (pipe_q[c].size() != 0 && pipe_q[c][0].t + lat == cyc) begin
      e = pipe_q[c].pop_front();
      f.id = e.id;
      f.p = e.p;
      fifo_q[c].push_back(f);
    end
    if (exp_rdy != 4'b0000) begin
      m_a[c] = a[win*22 +: 22];
      m_b[c] = b[win*22 +: 22];
      e.id = 2'(win);
      e.p = 44'(m_a[c]) * 44'(m_b[c]);
      e.t = cyc;
      pipe_q[c].push_back(e);
      m_ptr[c] = win;
    end
  endtask

  // Compare process.
  initial begin
    forever begin
      @(negedge clk);
      model_step(0, 1, req_valid0, req_ready0, req_a0, req_b0, rsp_valid0, rsp_ready0,
                 rsp_id0, rsp_p0, busy0, mult_a0, mult_b0);
      model_step(1, 3, req_valid1, req_ready1, req_a1, req_b1, rsp_valid1, rsp_ready1,
                 rsp_id1, rsp_p1, busy1, mult_a1, mult_b1);
      cyc++;
    end
  end

  // Requester and consumer drivers: hold valid and operands until accepted.
  initial begin
    logic [3:0]  acc [2];
    logic [3:0]  v [2];
    logic [87:0] a [2];
    logic [87:0] b [2];
    logic        rr [2];
    for (int c = 0; c < 2; c++) begin
      v[c] = 4'h0; a[c] = 88'h0; b[c] = 88'h0; rr[c] = 1'b1; acc[c] = 4'h0;
    end
    req_valid0 = 4'h0; req_valid1 = 4'h0;
    req_a0 = 88'h0; req_a1 = 88'h0; req_b0 = 88'h0; req_b1 = 88'h0;
    rsp_ready0 = 1'b1; rsp_ready1 = 1'b1;
    forever begin
      @(negedge clk);
      acc[0] = req_valid0 & req_ready0;
      acc[1] = req_valid1 & req_ready1;
      @(posedge clk);
      #1;
      for (int c = 0; c < 2; c++) begin
        for (int i = 0; i < 4; i++) begin
          if (!rst_n) begin
            v[c][i] = 1'b0;
          end else if (acc[c][i] || !v[c][i]) begin
            v[c][i] = g_mask[c][i] & (g_vrand ? 1'($urandom_range(0, 1)) : 1'b1);
            case (g_opmode)
              1: begin a[c][i*22 +: 22] = 22'(i + 1); b[c][i*22 +: 22] = 22'd3; end
              2: begin a[c][i*22 +: 22] = 22'h3FFFFF; b[c][i*22 +: 22] = 22'h3FFFFF; end
              default: begin
                a[c][i*22 +: 22] = ($urandom_range(0, 7) == 0) ? 22'h3FFFFF : 22'($urandom);
                b[c][i*22 +: 22] = ($urandom_range(0, 7) == 0) ? 22'h3FFFFF : 22'($urandom);
              end
            endcase
          end
        end
        rr[c] = (g_rmode[c] == 0) ? 1'b1 : (g_rmode[c] == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      end
      req_valid0 = v[0]; req_valid1 = v[1];
      req_a0 = a[0]; req_a1 = a[1]; req_b0 = b[0]; req_b1 = b[1];
      rsp_ready0 = rr[0]; rsp_ready1 = rr[1];
    end
  end

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int cnt;
    logic [3:0] eg;
    rst_n = 1'b0;
    g_mask[0] = 4'h0; g_mask[1] = 4'h0;
    g_rmode[0] = 0; g_rmode[1] = 0;
    g_opmode = 0;
    g_vrand = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_outs", {req_ready0, rsp_valid0, busy0, mult_a0, mult_b0}, 64'h0);
    rst_n = 1'b1;

    // Single full-scale request from requester 2.
    g_opmode = 2;
    g_mask[0] = 4'b0100;
    @(posedge clk);
    @(negedge clk);
    chk("t1_ready", req_ready0, 4'b0100);
    g_mask[0] = 4'h0;
    @(negedge clk);
    @(negedge clk);
    chk("t1_rsp_valid", rsp_valid0, 1'b1);
    chk("t1_rsp_id", rsp_id0, 2'd2);
    chk("t1_rsp_p", rsp_p0, 44'hFFFFF800001);
    chk("t1_busy", busy0, 1'b1);
    @(negedge clk);
    chk("t1_idle", {busy0, rsp_valid0}, 2'b00);

    // All requesters streaming: grants rotate 1,2,3,0.
    do_reset();
    g_opmode = 1;
    g_mask[0] = 4'hF;
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      eg = 4'b0001 << ((k + 1) % 4);
      chk($sformatf("t2_grant%0d", k), req_ready0, eg);
    end

    // Backpressure: exactly DEPTH accepts, then resume one cycle after the first pop.
    g_mask[0] = 4'h0;
    do_reset();
    g_rmode[0] = 1;
    g_mask[0] = 4'hF;
    @(posedge clk);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (req_ready0 != 4'h0) cnt++;
    end
    chk("t3_accepts", 64'(cnt), 64'd4);
    chk("t3_stalled", req_ready0, 4'h0);
    g_rmode[0] = 0;
    @(negedge clk);
    chk("t3_no_early_credit", {rsp_ready0, req_ready0}, 5'b10000);
    @(negedge clk);
    chk("t3_resume", req_ready0 != 4'h0, 1'b1);

    // Reset with one product in flight and two buffered.
    g_mask[0] = 4'h0;
    do_reset();
    g_rmode[0] = 1;
    g_mask[0] = 4'hF;
    repeat (4) @(posedge clk);
    #2;
    chk("t5_loaded", {rsp_valid0, busy0}, 2'b11);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_async_clear", {req_ready0, rsp_valid0, busy0, mult_a0, mult_b0}, 64'h0);
    g_rmode[0] = 0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_no_stale", {rsp_valid0, busy0}, 2'b00);
    @(negedge clk);
    chk("t5_first_grant", req_ready0, 4'b0010);

    // Latency-3 instance: requester 0 streaming.
    g_mask[0] = 4'h0;
    g_opmode = 0;
    do_reset();
    g_mask[1] = 4'b0001;
    g_rmode[1] = 0;
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k <= 4) chk($sformatf("t6_b2b%0d", k), req_ready1, 4'b0001);
      if (k == 4) chk("t6_not_yet", rsp_valid1, 1'b0);
      if (k == 5) chk("t6_lat4", rsp_valid1, 1'b1);
    end

    // Randomized traffic on both instances.
    g_vrand = 1'b1;
    g_mask[0] = 4'hF; g_mask[1] = 4'hF;
    g_rmode[0] = 2; g_rmode[1] = 2;
    repeat (800) @(posedge clk);

    // Drain.
    g_vrand = 1'b0;
    g_mask[0] = 4'h0; g_mask[1] = 4'h0;
    g_rmode[0] = 0; g_rmode[1] = 0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("drain_idle", {busy0, busy1}, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
